// File: rtl/event_core_if.sv
// Dispatch/return signal bundle of one event_core: dispatcher input, monitor stall/GVT, queue return path.
interface event_core_if #(
    parameter int MSG_WID  = 32,
    parameter int TIME_WID = 16,
    parameter int NB_CORE  = 2
);
    logic [MSG_WID-1:0]  in_msg;
    logic                in_vld;
    logic                in_rdy;
    logic                stall;
    logic [TIME_WID-1:0] gvt;
    logic                gvt_vld;
    logic [MSG_WID-1:0]  out_msg;
    logic                out_vld;
    logic                out_rdy;
    logic [NB_CORE-1:0]  out_core_id;
    logic [15:0]         evt_count;
    logic                caus_err;

    modport master (
        output in_msg, in_vld, stall, gvt, gvt_vld, out_rdy,
        input  in_rdy, out_msg, out_vld, out_core_id, evt_count, caus_err
    );

    modport slave (
        input  in_msg, in_vld, stall, gvt, gvt_vld, out_rdy,
        output in_rdy, out_msg, out_vld, out_core_id, evt_count, caus_err
    );
endinterface

// File: rtl/event_core.sv
// Processing-element endpoint: accepts one event, waits out the monitor stall, models LP processing,
// then returns one LFSR-generated event. Optional causality check under EVENT_CORE_CAUSALITY_CHK_EN.
module event_core #(
    parameter int CORE_ID     = 0,
    parameter int NUM_CORE    = 4,
    parameter int NUM_LP      = 8,
    parameter int TIME_WID    = 16,
    parameter int MSG_WID     = 32,
    parameter int PROC_CYCLES = 4
) (
    input logic         clk,
    input logic         reset_n,
    event_core_if.slave bus
);
    localparam int          NB_LP     = $clog2(NUM_LP);
    localparam int          NB_CORE   = $clog2(NUM_CORE);
    localparam int          CNT_WID   = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1 ^ 16'(CORE_ID);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_PROC,
        S_SEND
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_next;
    logic [CNT_WID-1:0]  r_cnt;
    logic [MSG_WID-1:0]  r_out_msg;
    logic [MSG_WID-1:0]  w_gen_msg;
    logic [15:0]         r_evt_count;
    logic                w_in_rdy;
    logic                w_out_vld;
    logic                w_accept;
    logic                w_send_done;
    logic [TIME_WID-1:0] w_in_time;
    logic [4:0]          w_delta;
    logic [TIME_WID:0]   w_time_sum;
    logic [TIME_WID-1:0] w_new_time;

    assign w_in_time   = bus.in_msg[TIME_WID-1:0];
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    assign w_delta     = {1'b0, w_lfsr_next[3:0]} + 5'd1;
    assign w_time_sum  = {1'b0, w_in_time} + (TIME_WID+1)'(w_delta);
    assign w_new_time  = w_time_sum[TIME_WID] ? '1 : w_time_sum[TIME_WID-1:0];

    always_comb begin
        w_gen_msg                      = '0;
        w_gen_msg[TIME_WID-1:0]        = w_new_time;
        w_gen_msg[TIME_WID +: NB_LP]   = w_lfsr_next[4 +: NB_LP];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_in_rdy     = 1'b0;
        w_out_vld    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_rdy = 1'b1;
                if (bus.in_vld) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!bus.stall) w_state_next = S_PROC;
            end
            S_PROC: begin
                if (r_cnt == '0) w_state_next = S_SEND;
            end
            S_SEND: begin
                w_out_vld = 1'b1;
                if (bus.out_rdy) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept    = w_in_rdy & bus.in_vld;
    assign w_send_done = w_out_vld & bus.out_rdy;

    // The generated event is fixed at accept time, which keeps out_msg stable for the whole of SEND.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr      <= LFSR_SEED;
            r_out_msg   <= '0;
            r_cnt       <= '0;
            r_evt_count <= '0;
        end else begin
            if (w_accept) begin
                r_lfsr    <= w_lfsr_next;
                r_out_msg <= w_gen_msg;
            end
            if (r_state == S_CHECK && !bus.stall) begin
                r_cnt <= CNT_WID'(PROC_CYCLES - 1);
            end else if (r_state == S_PROC) begin
                r_cnt <= r_cnt - CNT_WID'(1);
            end
            if (w_send_done) r_evt_count <= r_evt_count + 16'd1;
        end
    end

    assign bus.in_rdy      = w_in_rdy;
    assign bus.out_vld     = w_out_vld;
    assign bus.out_msg     = r_out_msg;
    assign bus.out_core_id = NB_CORE'(CORE_ID);
    assign bus.evt_count   = r_evt_count;

`ifdef EVENT_CORE_CAUSALITY_CHK_EN
    logic r_caus_err;
    logic w_unused_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_caus_err <= 1'b0;
        end else if (w_accept && bus.gvt_vld && (w_in_time < bus.gvt)) begin
            r_caus_err <= 1'b1;
        end
    end

    assign bus.caus_err  = r_caus_err;
    assign w_unused_bits = ^bus.in_msg[MSG_WID-1:TIME_WID];
`else
    logic w_unused_bits;

    assign bus.caus_err  = 1'b0;
    assign w_unused_bits = ^{bus.in_msg[MSG_WID-1:TIME_WID], bus.gvt, bus.gvt_vld};
`endif
endmodule

// File: tb/tb_event_core.sv
// Self-checking bench for event_core: directed vector table, randomized events against a
// reference model, reset during processing and the causality flag.
module tb_event_core;
    localparam int          CORE_ID     = 0;
    localparam int          NUM_CORE    = 4;
    localparam int          NUM_LP      = 8;
    localparam int          TIME_WID    = 16;
    localparam int          MSG_WID     = 32;
    localparam int          PROC_CYCLES = 4;
    localparam logic [15:0] SEED        = 16'hACE1 ^ 16'(CORE_ID);

    logic clk;
    logic reset_n;

    event_core_if #(.MSG_WID(MSG_WID), .TIME_WID(TIME_WID), .NB_CORE($clog2(NUM_CORE))) bus ();

    event_core #(
        .CORE_ID(CORE_ID), .NUM_CORE(NUM_CORE), .NUM_LP(NUM_LP),
        .TIME_WID(TIME_WID), .MSG_WID(MSG_WID), .PROC_CYCLES(PROC_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] model_lfsr;
    logic [15:0] model_count;
    logic        exp_caus;

    typedef struct {
        logic [31:0] msg;
        int          stall_cyc;
        int          bp_cyc;
        logic [31:0] exp_msg;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: one step of x^16 polynomial division, and the generated event as plain arithmetic.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [31:0] gen_msg(input logic [15:0] s, input logic [15:0] t);
        int unsigned sum;
        int unsigned lp;
        sum = int'(t) + int'(s % 16) + 1;
        if (sum > 32'hFFFF) sum = 32'hFFFF;
        lp = (int'(s) / 16) % NUM_LP;
        return (lp << TIME_WID) | sum;
    endfunction

    task automatic model_reset();
        model_lfsr  = SEED;
        model_count = '0;
        exp_caus    = 1'b0;
    endtask

    task automatic resync();
        bus.in_vld  = 1'b0;
        bus.stall   = 1'b0;
        bus.out_rdy = 1'b1;
        reset_n     = 1'b0;
        #3;
        reset_n     = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic run_event(input logic [31:0] msg, input int stall_cyc, input int bp_cyc,
                             input logic [31:0] exp_msg, input string tag);
        int          cyc;
        int          budget;
        logic        rdy_seen;
        logic        stable_ok;
        logic [31:0] held;
        check({tag, " in_rdy before accept"}, 64'(bus.in_rdy), 64'(1));
        bus.in_msg  = msg;
        bus.in_vld  = 1'b1;
        bus.out_rdy = (bp_cyc == 0);
        tick();
        model_lfsr = lfsr_step(model_lfsr);
`ifdef EVENT_CORE_CAUSALITY_CHK_EN
        if (bus.gvt_vld && (msg[15:0] < bus.gvt)) exp_caus = 1'b1;
`endif
        cyc       = 1;
        budget    = PROC_CYCLES + 2 + stall_cyc + 8;
        rdy_seen  = 1'b0;
        bus.stall = (stall_cyc >= 1);
        bus.in_vld = 1'($urandom_range(0, 1));
        bus.in_msg = $urandom;
        while (!bus.out_vld && cyc < budget) begin
            rdy_seen = rdy_seen | bus.in_rdy;
            tick();
            cyc++;
            bus.stall  = (cyc <= stall_cyc);
            bus.in_vld = 1'($urandom_range(0, 1));
            bus.in_msg = $urandom;
        end
        check({tag, " latency"}, 64'(cyc), 64'(PROC_CYCLES + 2 + stall_cyc));
        if (!bus.out_vld) begin
            resync();
            return;
        end
        check({tag, " out_msg"}, 64'(bus.out_msg), 64'(exp_msg));
        check({tag, " out_core_id"}, 64'(bus.out_core_id), 64'(CORE_ID));
        held      = bus.out_msg;
        stable_ok = 1'b1;
        for (int b = 0; b < bp_cyc; b++) begin
            rdy_seen = rdy_seen | bus.in_rdy;
            tick();
            stable_ok = stable_ok & (bus.out_vld === 1'b1) & (bus.out_msg === held);
            bus.in_vld = 1'($urandom_range(0, 1));
            bus.in_msg = $urandom;
            if (b == bp_cyc - 1) bus.out_rdy = 1'b1;
        end
        rdy_seen = rdy_seen | bus.in_rdy;
        if (bp_cyc > 0) check({tag, " held under backpressure"}, 64'(stable_ok), 64'(1));
        tick();
        bus.in_vld  = 1'b0;
        model_count = model_count + 16'd1;
        check({tag, " in_rdy low while busy"}, 64'(rdy_seen), 64'(0));
        check({tag, " out_vld after handshake"}, 64'(bus.out_vld), 64'(0));
        check({tag, " in_rdy after handshake"}, 64'(bus.in_rdy), 64'(1));
        check({tag, " evt_count"}, 64'(bus.evt_count), 64'(model_count));
        check({tag, " caus_err"}, 64'(bus.caus_err), 64'(exp_caus));
    endtask

    initial begin
        logic [31:0] msg;
        logic [15:0] t;
        logic        vld_seen;

        vecs[0] = '{32'h0003_0010, 0, 0, 32'h0007_0011};
        vecs[1] = '{32'h0001_0100, 5, 0, 32'h0003_0109};
        vecs[2] = '{32'h0005_1234, 0, 3, 32'h0001_1241};
        vecs[3] = '{32'h0002_FFFF, 0, 0, 32'h0004_FFFF};
        vecs[4] = '{32'h0007_FFF8, 2, 1, 32'h0002_FFFF};
        vecs[5] = '{32'h0000_FFFB, 1, 2, 32'h0001_FFFF};

        reset_n     = 1'b0;
        bus.in_msg  = '0;
        bus.in_vld  = 1'b0;
        bus.stall   = 1'b0;
        bus.gvt     = '0;
        bus.gvt_vld = 1'b0;
        bus.out_rdy = 1'b1;
        model_reset();
        #22;
        reset_n = 1'b1;
        tick();
        check("reset in_rdy", 64'(bus.in_rdy), 64'(1));
        check("reset out_vld", 64'(bus.out_vld), 64'(0));
        check("reset out_msg", 64'(bus.out_msg), 64'(0));
        check("reset evt_count", 64'(bus.evt_count), 64'(0));
        check("reset caus_err", 64'(bus.caus_err), 64'(0));

        for (int i = 0; i < 6; i++) begin
            run_event(vecs[i].msg, vecs[i].stall_cyc, vecs[i].bp_cyc, vecs[i].exp_msg,
                      $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            t = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 3) == 0) t = 16'hFFF0 + 16'($urandom_range(0, 15));
            msg       = $urandom;
            msg[15:0] = t;
            run_event(msg, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      gen_msg(lfsr_step(model_lfsr), t), $sformatf("rand%0d", i));
        end

        // Reset while in PROC: the in-flight event must vanish without a partial output.
        check("pre-reset in_rdy", 64'(bus.in_rdy), 64'(1));
        bus.in_msg = 32'h0006_0200;
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        bus.stall  = 1'b0;
        tick();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid-reset in_rdy", 64'(bus.in_rdy), 64'(1));
        check("mid-reset out_vld", 64'(bus.out_vld), 64'(0));
        check("mid-reset evt_count", 64'(bus.evt_count), 64'(0));
        check("mid-reset out_msg", 64'(bus.out_msg), 64'(0));
        #2;
        reset_n = 1'b1;
        model_reset();
        vld_seen = 1'b0;
        for (int i = 0; i < PROC_CYCLES + 6; i++) begin
            tick();
            vld_seen = vld_seen | bus.out_vld;
        end
        check("dropped event no out_vld", 64'(vld_seen), 64'(0));
        run_event(32'h0003_0010, 0, 0, 32'h0007_0011, "after reset");

        // Causality: time equal to gvt is legal, an earlier time is not, and the flag is sticky.
        bus.gvt     = 16'h0020;
        bus.gvt_vld = 1'b1;
        run_event(32'h0000_0020, 0, 0, gen_msg(lfsr_step(model_lfsr), 16'h0020), "caus equal");
        run_event(32'h0000_0010, 0, 0, gen_msg(lfsr_step(model_lfsr), 16'h0010), "caus early");
        run_event(32'h0000_0030, 1, 1, gen_msg(lfsr_step(model_lfsr), 16'h0030), "caus sticky");
        bus.gvt_vld = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
